// File: rtl/mult_job_sequencer_if.sv
// Bundle of the operand input, multiplier control/datapath and product output
// signals between mult_job_sequencer (slave) and its surroundings (master).
interface mult_job_sequencer_if #(
  parameter int WIDTH = 4
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; a raised valid keeps its payload stable until that transfer.
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_multiplicand;
  logic [WIDTH-1:0]     in_multiplier;
  logic                 mult_start;
  logic [WIDTH-1:0]     mult_multiplicand;
  logic [WIDTH-1:0]     mult_multiplier;
  logic                 mult_product_done;
  logic [2*WIDTH-1:0]   mult_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;

  modport master (
    output in_valid, in_multiplicand, in_multiplier,
    output mult_product_done, mult_product, out_ready,
    input  in_ready, mult_start, mult_multiplicand, mult_multiplier,
    input  out_valid, out_product
  );

  modport slave (
    input  in_valid, in_multiplicand, in_multiplier,
    input  mult_product_done, mult_product, out_ready,
    output in_ready, mult_start, mult_multiplicand, mult_multiplier,
    output out_valid, out_product
  );
endinterface

// File: rtl/mult_job_sequencer.sv
// Buffers operand pairs, runs one multiplier job at a time, and holds each product
// on a valid/ready output. Define MULT_SEQ_JOB_COUNT_EN to add the jobs_done counter.
module mult_job_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_job_sequencer_if.slave  bus,
  output logic [1:0]           state_dbg
`ifdef MULT_SEQ_JOB_COUNT_EN
  ,
  output logic [15:0]          jobs_done
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_product_q, out_product_d;

  logic push;
  logic pop;
  logic slot_free;

  // in_ready looks only at the registered count, so a full FIFO refuses even in a pop cycle.
  assign bus.in_ready    = (count_q < FULL_C);
  assign bus.mult_start  = (state_q == S_ISSUE);
  assign {bus.mult_multiplicand, bus.mult_multiplier} = mem_q[rd_ptr_q];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign state_dbg       = state_q;

  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    push      = bus.in_valid && bus.in_ready;
    // The head leaves only once its product is taken, keeping operands steady for the job.
    pop       = (state_q == S_CAPTURE) && slot_free;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_multiplicand, bus.in_multiplier};
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (count_q != '0) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (bus.mult_product_done) state_d = S_CAPTURE;
      S_CAPTURE: if (pop) state_d = (count_q > ONE_C) ? S_ISSUE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A capture in the same cycle as out_ready refills the slot rather than clearing it.
    out_valid_d = out_valid_q;
    if (pop) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    out_product_d = pop ? bus.mult_product : out_product_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
    end
  end

`ifdef MULT_SEQ_JOB_COUNT_EN
  logic [15:0] jobs_done_q, jobs_done_d;

  // Counts output transfers; wraps naturally at 16 bits.
  always_comb begin
    jobs_done_d = jobs_done_q;
    if (out_valid_q && bus.out_ready) begin
      jobs_done_d = jobs_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done_q <= '0;
    end else begin
      jobs_done_q <= jobs_done_d;
    end
  end

  assign jobs_done = jobs_done_q;
`else
  // Without the counter option there is no transfer count to keep.
`endif

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: behavioural multiplier model, queue scoreboard
// and directed plus randomized scenarios.
module tb_mult_job_sequencer;
  localparam int W   = 4;
  localparam int D   = 4;
  localparam int P   = 2 * W;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst;
  logic spurious_done;
  logic [1:0] state_dbg;
`ifdef MULT_SEQ_JOB_COUNT_EN
  logic [15:0] jobs_done;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [P-1:0] exp_q[$];
  logic [P-1:0] got_q[$];

  mult_job_sequencer_if #(.WIDTH(W)) bus();

  mult_job_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef MULT_SEQ_JOB_COUNT_EN
    ,
    .jobs_done (jobs_done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Multiplier model: done LAT cycles after start; product lands one edge after done,
  // computed from the operands present at the end of the job.
  int           mcnt;
  logic         mbusy;
  logic [P-1:0] mprod;

  assign bus.mult_product_done = (mbusy && mcnt == LAT) || spurious_done;
  assign bus.mult_product      = mprod;

  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      mcnt  <= 0;
      mprod <= '0;
    end else if (bus.mult_start) begin
      mbusy <= 1'b1;
      mcnt  <= 1;
      mprod <= P'($urandom);
    end else if (mbusy) begin
      if (mcnt == LAT) begin
        mbusy <= 1'b0;
        mprod <= P'(bus.mult_multiplicand) * P'(bus.mult_multiplier);
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  // Scoreboard: accepted pairs queue their products; every output transfer pops one.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        got_q.push_back(bus.out_product);
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard: unexpected product %0d with nothing pending", bus.out_product);
        end else begin
          if (bus.out_product !== exp_q[0]) begin
            miscompares++;
            $display("FAIL scoreboard: product %0d, expected %0d", bus.out_product, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(P'(bus.in_multiplicand) * P'(bus.in_multiplier));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    spurious_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_multiplicand = '0;
    bus.in_multiplier = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors += 5;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_product !== '0) begin miscompares++; $display("FAIL reset_out_product: got %0d, expected 0", bus.out_product); end
    if (bus.mult_start !== 1'b0) begin miscompares++; $display("FAIL reset_mult_start: got %b, expected 0", bus.mult_start); end
    if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d, expected 0", state_dbg); end
    tick();
  endtask

  task automatic test_single_job();
    int start_cyc = -1;
    int ov_cyc = -1;
    int starts = 0;
    int ir_low = 0;
    logic [P-1:0] prod = '0;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_multiplicand = W'(7);
    bus.in_multiplier = W'(13);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mult_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (bus.out_valid && ov_cyc < 0) begin
        ov_cyc = c;
        prod = bus.out_product;
      end
      if (!bus.in_ready) ir_low++;
      tick();
      if (c == 0) bus.in_valid = 1'b0;
    end
    vectors += 5;
    if (start_cyc != 2) begin miscompares++; $display("FAIL single_start_cycle: got %0d, expected 2", start_cyc); end
    if (starts != 1) begin miscompares++; $display("FAIL single_start_count: got %0d, expected 1", starts); end
    if (ov_cyc != 2 * W + 5) begin miscompares++; $display("FAIL single_out_valid_cycle: got %0d, expected %0d", ov_cyc, 2 * W + 5); end
    if (prod !== P'(91)) begin miscompares++; $display("FAIL single_product: got %0d, expected 91", prod); end
    if (ir_low != 0) begin miscompares++; $display("FAIL single_in_ready: low for %0d cycles, expected 0", ir_low); end
  endtask

  task automatic test_back_to_back();
    int start_c[$];
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [P-1:0] expv [3];
    av[0] = W'(15); bv[0] = W'(15); expv[0] = P'(225);
    av[1] = W'(0);  bv[1] = W'(9);  expv[1] = P'(0);
    av[2] = W'(1);  bv[2] = W'(1);  expv[2] = P'(1);
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c < 3) begin
        bus.in_valid = 1'b1;
        bus.in_multiplicand = av[c];
        bus.in_multiplier = bv[c];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.mult_start) start_c.push_back(c);
      tick();
    end
    vectors++;
    if (start_c.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_start_count: got %0d, expected 3", start_c.size());
    end else begin
      vectors += 2;
      if (start_c[1] - start_c[0] != 2 * W + 3) begin miscompares++; $display("FAIL b2b_gap1: got %0d, expected %0d", start_c[1] - start_c[0], 2 * W + 3); end
      if (start_c[2] - start_c[1] != 2 * W + 3) begin miscompares++; $display("FAIL b2b_gap2: got %0d, expected %0d", start_c[2] - start_c[1], 2 * W + 3); end
    end
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_result_count: got %0d, expected 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_q[k] !== expv[k]) begin miscompares++; $display("FAIL b2b_product%0d: got %0d, expected %0d", k, got_q[k], expv[k]); end
      end
    end
  endtask

  task automatic test_full_fifo();
    int waited;
    logic acc;
    logic ov_at;
    int n;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_multiplicand = W'(i);
      bus.in_multiplier = W'(1);
      waited = 0;
      acc = 1'b0;
      ov_at = 1'b0;
      while (!acc && waited < 100) begin
        @(negedge clk);
        acc = bus.in_ready;
        ov_at = bus.out_valid;
        tick();
        if (!acc) waited++;
      end
      bus.in_valid = 1'b0;
      if (i <= 4) begin
        vectors++;
        if (!acc || waited != 0) begin miscompares++; $display("FAIL full_push%0d: waited %0d cycles, expected 0", i, waited); end
      end
      if (i == 4) begin
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b, expected 0", bus.in_ready); end
        tick();
      end
      if (i == 5) begin
        vectors += 2;
        if (!acc || waited == 0) begin miscompares++; $display("FAIL full_push5_refused: accepted=%b waited=%0d, expected refusal then accept", acc, waited); end
        if (ov_at !== 1'b1) begin miscompares++; $display("FAIL full_push5_after_pop: out_valid=%b at accept, expected 1", ov_at); end
      end
    end
    // Stalled second capture keeps the FIFO full.
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) n++;
      tick();
    end
    vectors++;
    if (n != 0) begin miscompares++; $display("FAIL full_stall_in_ready: high for %0d cycles, expected 0", n); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_multiplicand = W'(6);
    bus.in_multiplier = W'(1);
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      waited++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (!acc) begin miscompares++; $display("FAIL full_push6: not accepted, expected accept"); end
    waited = 0;
    while (got_q.size() < 6 && waited < 200) begin tick(); waited++; end
    vectors++;
    if (got_q.size() != 6) begin
      miscompares++;
      $display("FAIL full_result_count: got %0d, expected 6", got_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (got_q[k] !== P'(k + 1)) begin miscompares++; $display("FAIL full_result%0d: got %0d, expected %0d", k, got_q[k], k + 1); end
      end
    end
  endtask

  task automatic test_output_stall();
    logic [W-1:0] a1, b1, a2, b2;
    logic found = 1'b0;
    int waited;
    a1 = W'($urandom_range(1, (1 << W) - 1));
    b1 = W'($urandom_range(1, (1 << W) - 1));
    a2 = W'($urandom_range(1, (1 << W) - 1));
    b2 = W'($urandom_range(1, (1 << W) - 1));
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_multiplicand = a1;
    bus.in_multiplier = b1;
    tick();
    bus.in_multiplicand = a2;
    bus.in_multiplier = b2;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (state_dbg == 2'd3 && bus.out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL stall_reached: capture stall never seen"); end
    for (int k = 0; k < 5; k++) begin
      vectors += 4;
      if (state_dbg !== 2'd3) begin miscompares++; $display("FAIL stall_state: got %0d, expected 3", state_dbg); end
      if (bus.mult_multiplicand !== a2) begin miscompares++; $display("FAIL stall_multiplicand: got %0d, expected %0d", bus.mult_multiplicand, a2); end
      if (bus.mult_multiplier !== b2) begin miscompares++; $display("FAIL stall_multiplier: got %0d, expected %0d", bus.mult_multiplier, b2); end
      if (bus.out_product !== P'(a1) * P'(b1)) begin miscompares++; $display("FAIL stall_out_product: got %0d, expected %0d", bus.out_product, P'(a1) * P'(b1)); end
      @(negedge clk);
    end
    tick();
    bus.out_ready = 1'b1;
    waited = 0;
    while (got_q.size() < 2 && waited < 100) begin tick(); waited++; end
    vectors++;
    if (got_q.size() != 2) begin
      miscompares++;
      $display("FAIL stall_result_count: got %0d, expected 2", got_q.size());
    end else begin
      vectors += 2;
      if (got_q[0] !== P'(a1) * P'(b1)) begin miscompares++; $display("FAIL stall_result0: got %0d, expected %0d", got_q[0], P'(a1) * P'(b1)); end
      if (got_q[1] !== P'(a2) * P'(b2)) begin miscompares++; $display("FAIL stall_result1: got %0d, expected %0d", got_q[1], P'(a2) * P'(b2)); end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [W-1:0] a, b;
    logic seen = 1'b0;
    int idle_bad = 0;
    int waited;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_multiplicand = W'($urandom_range(0, (1 << W) - 1));
    bus.in_multiplier = W'($urandom_range(0, (1 << W) - 1));
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mult_start) begin seen = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL midrst_start: no start pulse seen"); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b, expected 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b, expected 1", bus.in_ready); end
    if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL midrst_state: got %0d, expected 0", state_dbg); end
    tick();
    spurious_done = 1'b1;
    tick();
    spurious_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (state_dbg != 2'd0 || bus.mult_start || bus.out_valid) idle_bad++;
      tick();
    end
    vectors++;
    if (idle_bad != 0) begin miscompares++; $display("FAIL midrst_idle: %0d busy cycles after flush, expected 0", idle_bad); end
    a = W'($urandom_range(0, (1 << W) - 1));
    b = W'($urandom_range(0, (1 << W) - 1));
    got_q.delete();
    bus.in_valid = 1'b1;
    bus.in_multiplicand = a;
    bus.in_multiplier = b;
    tick();
    bus.in_valid = 1'b0;
    waited = 0;
    while (got_q.size() < 1 && waited < 60) begin tick(); waited++; end
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== P'(a) * P'(b)) begin
      miscompares++;
      $display("FAIL midrst_new_job: got %0d results (first %0d), expected one product %0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : P'(0), P'(a) * P'(b));
    end
  endtask

  task automatic test_random();
    int waited = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_multiplicand = W'($urandom_range(0, (1 << W) - 1));
      bus.in_multiplier = W'($urandom_range(0, (1 << W) - 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && waited < 1000) begin tick(); waited++; end
    vectors += 2;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL random_drain: %0d products pending, expected 0", exp_q.size()); end
    if (got_q.size() < 10) begin miscompares++; $display("FAIL random_volume: %0d products delivered, expected at least 10", got_q.size()); end
  endtask

`ifdef MULT_SEQ_JOB_COUNT_EN
  task automatic test_job_count();
    int waited = 0;
    do_reset();
    @(negedge clk);
    vectors++;
    if (jobs_done !== 16'd0) begin miscompares++; $display("FAIL jobs_reset0: got %0d, expected 0", jobs_done); end
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_multiplicand = W'($urandom_range(0, (1 << W) - 1));
      bus.in_multiplier = W'($urandom_range(0, (1 << W) - 1));
      tick();
    end
    bus.in_valid = 1'b0;
    while (got_q.size() < 3 && waited < 100) begin tick(); waited++; end
    repeat (2) tick();
    @(negedge clk);
    vectors++;
    if (jobs_done !== 16'd3) begin miscompares++; $display("FAIL jobs_count3: got %0d, expected 3", jobs_done); end
    tick();
    do_reset();
    @(negedge clk);
    vectors++;
    if (jobs_done !== 16'd0) begin miscompares++; $display("FAIL jobs_reset1: got %0d, expected 0", jobs_done); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_full_fifo();
    test_output_stall();
    test_reset_mid_job();
    test_random();
`ifdef MULT_SEQ_JOB_COUNT_EN
    test_job_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Feeds operand pairs to MultiplierControl_ConstantTime and its datapath, and collects the products.
- Buffers incoming operand pairs in a small FIFO and issues one job at a time with a single-cycle start pulse.
- Holds operands stable for the whole job, captures the product after the done pulse, and presents it on a valid/ready output.

Parameters:
- WIDTH, 4, operand width; must match the multiplier WIDTH.
- DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept a pair.
- in_multiplicand  input  WIDTH  multiplicand.
- in_multiplier  input  WIDTH  multiplier.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- mult_multiplicand  output  WIDTH  FIFO head multiplicand; stable during a job.
- mult_multiplier  output  WIDTH  FIFO head multiplier; stable during a job.
- mult_product_done  input  1  productDone pulse from the multiplier.
- mult_product  input  2*WIDTH  product register from the datapath.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_product  output  2*WIDTH  registered product.

Behaviour:
- Reset: FIFO pointers and count = 0, state = IDLE, out_valid = 0, out_product = 0, mult_start = 0.
  - in_ready = 1 after reset.
  - Reset mid-job abandons the job and flushes the FIFO. The multiplier shares rst.
- Input handshake:
  - Push on in_valid && in_ready.
  - in_ready = (count < DEPTH), registered-count based.
  - No same-cycle bypass of a pop into free space: a full FIFO deasserts in_ready even in a pop cycle.
- Operand outputs: mult_multiplicand/mult_multiplier are driven from the FIFO head at all times. The head is popped only in CAPTURE, so operands stay stable from ISSUE until the product is taken.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE: count != 0 -> ISSUE.
  - ISSUE: mult_start = 1 for exactly this cycle -> WAIT.
  - WAIT: mult_product_done = 1 -> CAPTURE.
  - CAPTURE: the multiplier's final shift has landed in this cycle, and the product register holds while the multiplier sits in START.
    - Free slot (!out_valid || out_ready): out_product <= mult_product, out_valid <= 1, pop FIFO; next state is ISSUE if count > 1, else IDLE.
    - Slot occupied: stay in CAPTURE, no pop, no capture.
- Timing: out_valid rises 2 cycles after the done pulse. With an empty pipeline and WIDTH=4, a pair accepted at cycle 0 gives start at cycle 2, done at cycle 11 and out_valid at cycle 13 (2*WIDTH+5).
- Output handshake:
  - out_valid clears on out_ready when no capture occurs in the same cycle.
  - A simultaneous out_ready and capture replaces the product and keeps out_valid = 1.
- Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
- mult_product_done outside WAIT is ignored.
- Back-to-back jobs: ISSUE follows CAPTURE directly; no IDLE bubble.

Optional Feature:
- Macro MULT_SEQ_JOB_COUNT_EN.
- Defined: adds output port jobs_done [15:0].
  - Increments on each out_valid && out_ready transfer and wraps at 16'hFFFF -> 0.
  - Reset value 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Single job: WIDTH=4, push 4'd7 x 4'd13 at cycle 0, out_ready=1 -> mult_start high only at cycle 2, out_valid at cycle 13 with out_product=8'd91, in_ready stays 1.
- Back-to-back: push (15,15), (0,9), (1,1) consecutively, out_ready=1 -> products 225, 0, 1 in order; each start pulse directly follows the previous CAPTURE.
- Full FIFO: DEPTH=4, push 6 pairs with out_ready=0 -> in_ready low once count=4.
  - The 5th pair is refused until the first CAPTURE pop.
  - Results 1..6 are delivered in order once out_ready=1.
- Output stall: out_ready=0 while the second product completes -> FSM holds in CAPTURE, mult_multiplicand/mult_multiplier unchanged.
  - Raising out_ready delivers product 1 then product 2 with no loss.
- Reset mid-job: assert rst during WAIT -> next cycle out_valid=0, in_ready=1, count=0.
  - A new pair pushed afterwards produces the correct product.
- MULT_SEQ_JOB_COUNT_EN defined: 3 completed transfers -> jobs_done=3; reset -> 0.
